// File: rtl/rx78_vram_arbiter.sv
// VRAM arbiter for the RX-78: shares one port per plane RAM between Z80 cycles and
// video fetches (video first), and owns the plane-mask I/O registers and vblank IRQ.
module rx78_vram_arbiter #(
  parameter int unsigned NPLANES   = 6,
  parameter int unsigned ADDR_W    = 13,
  parameter logic [15:0] VRAM_BASE = 16'hEC00,
  parameter logic [7:0]  RD_PORT   = 8'hF1,
  parameter logic [7:0]  WR_PORT   = 8'hF2,
  parameter logic [7:0]  ACK_PORT  = 8'hF0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             cpu_din,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  output logic                   wait_n,
  output logic                   int_n,
  input  logic                   vb,
  input  logic                   vid_req,
  input  logic [ADDR_W-1:0]      vid_addr,
  output logic [NPLANES*8-1:0]   vid_data,
  output logic                   vid_valid,
  output logic [ADDR_W-1:0]      plane_addr,
  output logic [7:0]             plane_wdata,
  output logic [NPLANES-1:0]     plane_we,
  input  logic [NPLANES*8-1:0]   plane_rdata
);

  typedef enum logic [2:0] {IDLE, VID, CPU_RD, CPU_WR, HOLD} state_t;

  state_t state, state_next;

  logic [NPLANES-1:0] rd_mask, wr_mask;
  logic               pending, vb_d, io_wr_d;
  logic [7:0]         rd_data, rd_merge;
  logic               mem_hit, io_wr, io_rd, io_wr_first;
  logic               irq_set, irq_clr;
  logic [ADDR_W-1:0]  cpu_off;

  assign mem_hit     = ~mreq_n & (~rd_n | ~wr_n) & (cpu_addr >= VRAM_BASE);
  assign cpu_off     = cpu_addr[ADDR_W-1:0] - VRAM_BASE[ADDR_W-1:0];
  assign io_wr       = ~iorq_n & ~wr_n & m1_n;
  assign io_rd       = ~iorq_n & ~rd_n & m1_n;
  // An OUT spans several clocks; only its first clock acts, so a vblank edge
  // landing mid-OUT to ACK_PORT is not wiped by the remaining cycles.
  assign io_wr_first = io_wr & ~io_wr_d;
  assign irq_set     = vb & ~vb_d;
  assign irq_clr     = (~m1_n & ~iorq_n) | (io_wr_first & (cpu_addr[7:0] == ACK_PORT));
  assign int_n       = ~pending;
  assign plane_wdata = cpu_dout;

  always_comb begin
    rd_merge = '0;
    for (int unsigned i = 0; i < NPLANES; i++) begin
      if (rd_mask[i]) rd_merge = rd_merge | plane_rdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    plane_addr = cpu_off;
    plane_we   = '0;
    wait_n     = 1'b1;
    case (state)
      IDLE: begin
        if (vid_req) begin
          plane_addr = vid_addr;
          state_next = VID;
        end else if (mem_hit && !rd_n) begin
          state_next = CPU_RD;
        end else if (mem_hit && !wr_n) begin
          plane_we   = wr_mask;
          state_next = CPU_WR;
        end
      end
      VID:            state_next = IDLE;
      CPU_RD, CPU_WR: state_next = HOLD;
      HOLD:           if (!mem_hit) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
    if (mem_hit && (state == IDLE || state == VID)) wait_n = 1'b0;
    // Combinational strobes must drop the moment reset asserts, even mid-write.
    if (!reset_n) begin
      plane_we = '0;
      wait_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_mask   <= '0;
      wr_mask   <= '0;
      pending   <= 1'b0;
      vb_d      <= 1'b0;
      io_wr_d   <= 1'b0;
      rd_data   <= '0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
    end else begin
      vb_d    <= vb;
      io_wr_d <= io_wr;
      if (irq_set)      pending <= 1'b1;
      else if (irq_clr) pending <= 1'b0;
      if (io_wr_first && cpu_addr[7:0] == RD_PORT) rd_mask <= cpu_dout[NPLANES-1:0];
      if (io_wr_first && cpu_addr[7:0] == WR_PORT) wr_mask <= cpu_dout[NPLANES-1:0];
      vid_valid <= (state == VID);
      if (state == VID) vid_data <= plane_rdata;
      if (state == CPU_RD)               rd_data <= rd_merge;
      else if (state == HOLD && !mem_hit) rd_data <= '0;
    end
  end

  always_comb begin
    cpu_din = rd_data;
    if (io_rd) begin
      case (cpu_addr[7:0])
        RD_PORT:  cpu_din = 8'(rd_mask);
        WR_PORT:  cpu_din = 8'(wr_mask);
        ACK_PORT: cpu_din = {7'b0, pending};
        default:  cpu_din = '0;
      endcase
    end
    if (!reset_n) cpu_din = '0;
  end

endmodule

// File: tb/tb_rx78_vram_arbiter.sv
// Bench for rx78_vram_arbiter: vector table, hand sequences for reset/IRQ/window
// corners, then random Z80 and video traffic against a shadow-memory model.
module tb_rx78_vram_arbiter;
  localparam int NP = 6;
  localparam logic [15:0] BASE = 16'hEC00;

  logic clk = 0, reset_n = 0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0, cpu_din;
  logic mreq_n = 1, iorq_n = 1, rd_n = 1, wr_n = 1, m1_n = 1;
  logic wait_n, int_n, vb = 0, vid_req = 0, vid_valid;
  logic [12:0] vid_addr = '0, plane_addr;
  logic [NP*8-1:0] vid_data, plane_rdata, rdata_q;
  logic [7:0] plane_wdata;
  logic [NP-1:0] plane_we;

  rx78_vram_arbiter #(.NPLANES(NP), .ADDR_W(13)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .wait_n(wait_n), .int_n(int_n), .vb(vb), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid), .plane_addr(plane_addr),
    .plane_wdata(plane_wdata), .plane_we(plane_we), .plane_rdata(plane_rdata));

  always #5 clk = ~clk;

  // Plane RAMs (environment) and the independent expected-contents model.
  logic [7:0] ram [NP][8192];
  logic [7:0] shadow [NP][8192];
  assign plane_rdata = rdata_q;
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      rdata_q[p*8 +: 8] <= ram[p][plane_addr];
      if (plane_we[p]) ram[p][plane_addr] = plane_wdata;
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int vid_cnt = 0, vid_cyc = 0, we_cnt = 0;
  logic [NP*8-1:0] vid_last;
  logic [NP-1:0] last_we;
  logic [12:0] last_we_addr;
  logic [7:0] last_wdata;
  always @(negedge clk) begin
    if (vid_valid === 1'b1) begin vid_cnt++; vid_cyc = cyc_n; vid_last = vid_data; end
    if (plane_we !== '0) begin
      we_cnt++; last_we = plane_we; last_we_addr = plane_addr; last_wdata = plane_wdata;
    end
  end

  int pass_cnt = 0, total_cnt = 0;
  logic [NP-1:0] m_rd = '0, m_wr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] addr);
    logic [12:0] off;
    logic [7:0] r;
    off = 13'(addr - BASE);
    r = '0;
    for (int p = 0; p < NP; p++) if (m_rd[p]) r = r | shadow[p][off];
    return r;
  endfunction

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    cpu_addr = {8'h00, port}; cpu_dout = d; iorq_n = 0; wr_n = 0;
    repeat (3) @(posedge clk);
    #1 iorq_n = 1; wr_n = 1;
    if (port == 8'hF1) m_rd = d[NP-1:0];
    if (port == 8'hF2) m_wr = d[NP-1:0];
    @(posedge clk); #1;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] d);
    cpu_addr = {8'h00, port}; iorq_n = 0; rd_n = 0;
    @(negedge clk); d = cpu_din;
    @(posedge clk); #1 iorq_n = 1; rd_n = 1;
    @(posedge clk); #1;
  endtask

  // One Z80 memory cycle, optionally colliding with a video request in its first clock.
  task automatic mem_access(input bit is_wr, input logic [15:0] addr, input logic [7:0] wdata,
                            input bit vid, input logic [12:0] vaddr, output logic [7:0] rdata);
    int start, lows, n, vcnt0, wcnt0;
    bit done;
    logic [NP*8-1:0] vexp;
    logic [12:0] off;
    off = 13'(addr - BASE);
    for (int p = 0; p < NP; p++) vexp[p*8 +: 8] = shadow[p][vaddr];
    vcnt0 = vid_cnt; wcnt0 = we_cnt; start = cyc_n;
    cpu_addr = addr; cpu_dout = wdata; mreq_n = 0;
    if (is_wr) wr_n = 0; else rd_n = 0;
    vid_req = vid; vid_addr = vaddr;
    lows = 0; n = 0; done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (wait_n === 1'b1) done = 1; else lows++;
      n++;
      @(posedge clk); #1 vid_req = 0;
    end
    check("wait_release", 32'(done), 1);
    rdata = '0;
    if (!is_wr) begin
      @(negedge clk); rdata = cpu_din;
      @(posedge clk); #1;
    end
    mreq_n = 1; rd_n = 1; wr_n = 1;
    @(posedge clk); #1;
    check("wait_low_cycles", 32'(lows), vid ? 3 : 1);
    if (vid) begin
      check("vid_pulses", 32'(vid_cnt - vcnt0), 1);
      check("vid_latency", 32'(vid_cyc - start), 2);
      check("vid_data", vid_last[31:0], vexp[31:0]);
      check("vid_data_hi", 32'(vid_last[NP*8-1:32]), 32'(vexp[NP*8-1:32]));
    end else check("vid_quiet", 32'(vid_cnt - vcnt0), 0);
    if (is_wr) begin
      check("we_cycles", 32'(we_cnt - wcnt0), (m_wr != '0) ? 1 : 0);
      if (m_wr != '0) begin
        check("we_mask", 32'(last_we), 32'(m_wr));
        check("we_addr", 32'(last_we_addr), 32'(off));
        check("we_data", 32'(last_wdata), 32'(wdata));
      end
      for (int p = 0; p < NP; p++) if (m_wr[p]) shadow[p][off] = wdata;
    end else check("rd_no_we", 32'(we_cnt - wcnt0), 0);
  endtask

  task automatic vid_only(input logic [12:0] va);
    int start, vcnt0;
    logic [NP*8-1:0] vexp;
    for (int p = 0; p < NP; p++) vexp[p*8 +: 8] = shadow[p][va];
    vcnt0 = vid_cnt; start = cyc_n;
    vid_req = 1; vid_addr = va;
    @(posedge clk); #1 vid_req = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("vo_pulses", 32'(vid_cnt - vcnt0), 1);
    check("vo_latency", 32'(vid_cyc - start), 2);
    check("vo_data", vid_last[31:0], vexp[31:0]);
  endtask

  typedef enum {OP_OUT, OP_IN, OP_MW, OP_MR} op_e;
  typedef struct { op_e op; logic [15:0] addr; logic [7:0] data; logic [7:0] exp; } vec_t;

  initial begin
    #500000 $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [7:0] d, e;
    int wcnt0;
    logic [15:0] a;

    vecs.push_back('{OP_OUT, 16'h00F2, 8'h01, 8'h00});
    vecs.push_back('{OP_MW,  16'hEC10, 8'h0F, 8'h00});
    vecs.push_back('{OP_OUT, 16'h00F2, 8'h02, 8'h00});
    vecs.push_back('{OP_MW,  16'hEC10, 8'hF0, 8'h00});
    vecs.push_back('{OP_OUT, 16'h00F1, 8'h03, 8'h00});
    vecs.push_back('{OP_MR,  16'hEC10, 8'h00, 8'hFF});
    vecs.push_back('{OP_OUT, 16'h00F1, 8'h00, 8'h00});
    vecs.push_back('{OP_MR,  16'hEC10, 8'h00, 8'h00});
    vecs.push_back('{OP_IN,  16'h00F1, 8'h00, 8'h00});
    vecs.push_back('{OP_IN,  16'h00F2, 8'h00, 8'h02});
    vecs.push_back('{OP_OUT, 16'h00F2, 8'h05, 8'h00});
    vecs.push_back('{OP_MW,  16'hEC10, 8'hAA, 8'h00});
    vecs.push_back('{OP_IN,  16'h00F2, 8'h00, 8'h05});
    vecs.push_back('{OP_OUT, 16'h00F1, 8'h01, 8'h00});
    vecs.push_back('{OP_MR,  16'hEC10, 8'h00, 8'hAA});
    vecs.push_back('{OP_OUT, 16'h00F1, 8'h02, 8'h00});
    vecs.push_back('{OP_MR,  16'hEC10, 8'h00, 8'hF0});
    vecs.push_back('{OP_OUT, 16'h00F1, 8'h04, 8'h00});
    vecs.push_back('{OP_MR,  16'hEC10, 8'h00, 8'hAA});
    vecs.push_back('{OP_OUT, 16'h00F2, 8'h00, 8'h00});
    vecs.push_back('{OP_MW,  16'hEC10, 8'h55, 8'h00});
    vecs.push_back('{OP_OUT, 16'h00F1, 8'h05, 8'h00});
    vecs.push_back('{OP_MR,  16'hEC10, 8'h00, 8'hAA});
    vecs.push_back('{OP_IN,  16'h00F1, 8'h00, 8'h05});
    vecs.push_back('{OP_IN,  16'h00F0, 8'h00, 8'h00});
    vecs.push_back('{OP_IN,  16'h0033, 8'h00, 8'h00});

    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 8192; i++) begin
        ram[p][i] = 8'((p * 59) ^ (i * 7) ^ (i >> 4));
        shadow[p][i] = ram[p][i];
      end

    // Reset state
    #3;
    check("rst_wait_n", 32'(wait_n), 1);
    check("rst_int_n", 32'(int_n), 1);
    check("rst_vid_valid", 32'(vid_valid), 0);
    check("rst_plane_we", 32'(plane_we), 0);
    check("rst_cpu_din", 32'(cpu_din), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;

    // Reset asserted during a write's arbitration cycle
    vb = 1; repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_irq", 32'(int_n), 0);
    vb = 0;
    io_write(8'hF2, 8'h03);
    cpu_addr = 16'hEC20; cpu_dout = 8'hC3; mreq_n = 0; wr_n = 0;
    @(negedge clk);
    check("pre_rst_we", 32'(plane_we), 32'h03);
    check("pre_rst_wait", 32'(wait_n), 0);
    #2 reset_n = 0;
    #1;
    check("mid_rst_we", 32'(plane_we), 0);
    check("mid_rst_wait", 32'(wait_n), 1);
    check("mid_rst_int", 32'(int_n), 1);
    #1 mreq_n = 1; wr_n = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1; m_rd = '0; m_wr = '0;
    @(posedge clk); #1;
    io_read(8'hF1, d); check("post_rst_rdmask", 32'(d), 0);
    io_read(8'hF2, d); check("post_rst_wrmask", 32'(d), 0);
    io_write(8'hF1, 8'h01);
    mem_access(0, 16'hEC20, 8'h00, 0, '0, d);
    check("dropped_write", 32'(d), 32'(shadow[0][13'h020]));

    // Vector table
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_OUT: io_write(vecs[i].addr[7:0], vecs[i].data);
        OP_IN: begin
          io_read(vecs[i].addr[7:0], d);
          check($sformatf("vec%0d_in", i), 32'(d), 32'(vecs[i].exp));
        end
        OP_MW: mem_access(1, vecs[i].addr, vecs[i].data, 0, '0, d);
        default: begin
          mem_access(0, vecs[i].addr, 8'h00, 0, '0, d);
          check($sformatf("vec%0d_mr", i), 32'(d), 32'(vecs[i].exp));
        end
      endcase
    end

    // Window edges
    io_write(8'hF2, 8'h3F);
    wcnt0 = we_cnt;
    cpu_addr = 16'hEBFF; cpu_dout = 8'h77; mreq_n = 0; rd_n = 0;
    @(negedge clk);
    check("ebff_rd_wait", 32'(wait_n), 1);
    check("ebff_rd_din", 32'(cpu_din), 0);
    @(posedge clk); #1 rd_n = 1; wr_n = 0;
    @(negedge clk);
    check("ebff_wr_wait", 32'(wait_n), 1);
    check("ebff_wr_we", 32'(plane_we), 0);
    repeat (2) @(posedge clk);
    #1 mreq_n = 1; wr_n = 1;
    @(posedge clk); #1;
    check("ebff_no_we", 32'(we_cnt - wcnt0), 0);
    io_write(8'hF2, 8'h01);
    mem_access(1, 16'hFFFF, 8'h5A, 0, '0, d);
    check("ffff_addr", 32'(last_we_addr), 32'h13FF);
    io_write(8'hF1, 8'h01);
    mem_access(0, 16'hFFFF, 8'h00, 0, '0, d);
    check("ffff_read", 32'(d), 32'h5A);

    // Collision: video and CPU read in the same cycle
    io_write(8'hF1, 8'h3F);
    e = exp_read(16'hEC00);
    mem_access(0, 16'hEC00, 8'h00, 1, 13'h0100, d);
    check("collide_read", 32'(d), 32'(e));

    // Interrupt
    vb = 1;
    @(negedge clk); check("irq_not_yet", 32'(int_n), 1);
    @(posedge clk); #1;
    @(negedge clk); check("irq_set", 32'(int_n), 0);
    @(posedge clk); #1;
    io_read(8'hF0, d); check("irq_ack_read", 32'(d), 1);
    iorq_n = 0; m1_n = 0;
    @(negedge clk); check("irq_intack_hold", 32'(int_n), 0);
    @(posedge clk); #1 iorq_n = 1; m1_n = 1;
    @(negedge clk); check("irq_intack_clr", 32'(int_n), 1);
    @(posedge clk); #1 vb = 0;
    @(posedge clk); #1;
    cpu_addr = 16'h00F0; cpu_dout = 8'h00; iorq_n = 0; wr_n = 0; vb = 1;
    repeat (3) @(posedge clk);
    #1 iorq_n = 1; wr_n = 1;
    @(negedge clk); check("irq_set_wins", 32'(int_n), 0);
    @(posedge clk); #1;
    io_write(8'hF0, 8'h00);
    check("irq_ack_port", 32'(int_n), 1);
    vb = 0;

    // Random traffic against the shadow model
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 6);
      a = BASE + 16'($urandom_range(0, 16'h13FF));
      case (op)
        0, 1: mem_access(1, a, 8'($urandom), ($urandom_range(0, 3) == 0), 13'($urandom), d);
        2, 3: begin
          e = exp_read(a);
          mem_access(0, a, 8'h00, ($urandom_range(0, 3) == 0), 13'($urandom), d);
          check("rand_read", 32'(d), 32'(e));
        end
        4: io_write(($urandom_range(0, 1) == 0) ? 8'hF1 : 8'hF2, 8'($urandom));
        5: begin
          io_read(8'hF1, d); check("rand_rdmask", 32'(d), 32'(m_rd));
          io_read(8'hF2, d); check("rand_wrmask", 32'(d), 32'(m_wr));
        end
        default: vid_only(13'($urandom));
      endcase
    end
    check("rand_int_n", 32'(int_n), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
